// File: rtl/down_counter_timer_pkg.sv
// Shared FSM state encodings for the loadable down-counter timer.
package down_counter_timer_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with optional auto-reload and a
// terminal-event counter. Single clock, synchronous active-high reset.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned bitwidth  = 6,
  parameter int unsigned evt_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [bitwidth-1:0]  load_value,
  input  logic                 enable,
  input  logic                 auto_reload,
  input  logic                 abort,
  output logic [bitwidth-1:0]  count_out,
  output logic                 busy,
  output logic                 tc_pulse,
  output logic [evt_width-1:0] tc_count
);

  logic                 r_state;
  logic [bitwidth-1:0]  r_count;
  logic [bitwidth-1:0]  r_reload;
  logic                 r_tc;
  logic [evt_width-1:0] r_tc_count;

  logic                 w_state_d;
  logic [bitwidth-1:0]  w_count_d;
  logic [bitwidth-1:0]  w_reload_d;
  logic                 w_tc_d;
  logic [evt_width-1:0] w_tc_count_d;
  logic                 w_accept;

  assign load_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept   = load_valid && load_ready;

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_reload_d   = r_reload;
    w_tc_d       = 1'b0;
    w_tc_count_d = r_tc_count;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (load_value != '0) begin
            w_count_d  = load_value;
            w_reload_d = load_value;
            w_state_d  = ST_RUN;
          end else begin
            // Zero-length timer: fire immediately without leaving IDLE.
            w_tc_d       = 1'b1;
            w_tc_count_d = r_tc_count + evt_width'(1);
          end
        end
      end
      default: begin
        if (abort) begin
          w_count_d = '0;
          w_state_d = ST_IDLE;
        end else if (enable) begin
          if (r_count > bitwidth'(1)) begin
            w_count_d = r_count - bitwidth'(1);
          end else begin
            w_tc_d       = 1'b1;
            w_tc_count_d = r_tc_count + evt_width'(1);
            if (auto_reload) begin
              w_count_d = r_reload;
            end else begin
              w_count_d = '0;
              w_state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_reload   <= '0;
      r_tc       <= 1'b0;
      r_tc_count <= '0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_reload   <= w_reload_d;
      r_tc       <= w_tc_d;
      r_tc_count <= w_tc_count_d;
    end
  end

  assign count_out = r_count;
  assign busy      = (r_state == ST_RUN);
  assign tc_pulse  = r_tc;
  assign tc_count  = r_tc_count;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: expected outputs are queued per step
// and compared one cycle later; a second instance checks 2-bit tc_count wrap.
module tb_down_counter_timer;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [5:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic       abort;

  logic       load_ready,  load_ready_w2;
  logic [5:0] count_out,   count_out_w2;
  logic       busy,        busy_w2;
  logic       tc_pulse,    tc_pulse_w2;
  logic [7:0] tc_count;
  logic [1:0] tc_count_w2;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0] cnt;
    logic       busy;
    logic       tc;
    logic       rdy;
    logic [7:0] tcc;
  } exp_t;

  exp_t sb_q[$];

  down_counter_timer #(.bitwidth(6), .evt_width(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .abort       (abort),
    .count_out   (count_out),
    .busy        (busy),
    .tc_pulse    (tc_pulse),
    .tc_count    (tc_count)
  );

  down_counter_timer #(.bitwidth(6), .evt_width(2)) u_dut_w2 (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready_w2),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .abort       (abort),
    .count_out   (count_out_w2),
    .busy        (busy_w2),
    .tc_pulse    (tc_pulse_w2),
    .tc_count    (tc_count_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then pop and compare them 1 time unit past the edge.
  task automatic step(input logic rst, input logic lv, input logic [5:0] val,
                      input logic en, input logic ar, input logic ab,
                      input logic [5:0] e_cnt, input logic e_busy, input logic e_tc,
                      input logic e_rdy, input logic [7:0] e_tcc);
    exp_t e;
    exp_t got;
    reset       = rst;
    load_valid  = lv;
    load_value  = val;
    enable      = en;
    auto_reload = ar;
    abort       = ab;
    e.cnt = e_cnt; e.busy = e_busy; e.tc = e_tc; e.rdy = e_rdy; e.tcc = e_tcc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("count_out",   32'(count_out),     32'(got.cnt));
    check("busy",        32'(busy),          32'(got.busy));
    check("tc_pulse",    32'(tc_pulse),      32'(got.tc));
    check("load_ready",  32'(load_ready),    32'(got.rdy));
    check("tc_count",    32'(tc_count),      32'(got.tcc));
    check("tc_count_w2", 32'(tc_count_w2),   32'(got.tcc[1:0]));
    check("count_w2",    32'(count_out_w2),  32'(got.cnt));
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_value = '0;
    enable = 1'b0; auto_reload = 1'b0; abort = 1'b0;

    // Reset state, including a load attempt while reset is high.
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0);

    // Load 5, enable held, no reload: 5,4,3,2,1,0 with pulse at 0.
    step(0, 1, 5, 1, 0, 0,  5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0,  4, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0,  3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0,  2, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1);

    // Load 3 with auto-reload: 3,2,1,3,2,1,3,2,1,3.
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 1, 0,  3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0,  2, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0,  3, 1, 1, 0, 1);
    step(0, 0, 0, 1, 1, 0,  2, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0,  3, 1, 1, 0, 2);
    step(0, 0, 0, 1, 1, 0,  2, 1, 0, 0, 2);
    step(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 2);
    step(0, 0, 0, 1, 1, 0,  3, 1, 1, 0, 3);
    step(0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 3);

    // Load 4, enable 1,0,0,1,1,1: 4,3,3,3,2,1,0.
    step(0, 1, 4, 1, 0, 0,  4, 1, 0, 0, 3);
    step(0, 0, 0, 1, 0, 0,  3, 1, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 3);
    step(0, 0, 0, 1, 0, 0,  2, 1, 0, 0, 3);
    step(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 3);
    step(0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 4);

    // Load 6, loads of 7 during RUN are ignored, abort at count 2.
    step(0, 1, 6, 0, 0, 0,  6, 1, 0, 0, 4);
    step(0, 1, 7, 1, 0, 0,  5, 1, 0, 0, 4);
    step(0, 1, 7, 1, 0, 0,  4, 1, 0, 0, 4);
    step(0, 0, 0, 1, 0, 0,  3, 1, 0, 0, 4);
    step(0, 0, 0, 1, 0, 0,  2, 1, 0, 0, 4);
    step(0, 0, 0, 1, 0, 1,  0, 0, 0, 1, 4);

    // Zero-length load.
    step(0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 5);
    step(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 5);

    // Five back-to-back zero loads from reset: 2-bit counter wraps 1,2,3,0,1.
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1);
    step(0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 2);
    step(0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 3);
    step(0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 4);
    step(0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 5);
    step(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 5);

    // Reset mid-RUN at count 3.
    step(0, 1, 5, 1, 0, 0,  5, 1, 0, 0, 5);
    step(0, 0, 0, 1, 0, 0,  4, 1, 0, 0, 5);
    step(0, 0, 0, 1, 0, 0,  3, 1, 0, 0, 5);
    step(1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
